// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit.
// Size codes, FSM state encoding and word geometry.
package dmem_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/dmem_lsu_lane.sv
// Little-endian lane extract (loads) and lane merge (sub-word stores).
// Size code 2'b11 behaves as a word access.
module dmem_lsu_lane
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        sgn_i,
   output logic [31:0] ext_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   always_comb begin
      byte_w   = word_i[{addr_i, 3'b000} +: 8];
      half_w   = addr_i[1] ? word_i[31:16] : word_i[15:0];
      ext_o    = word_i;
      merged_o = wdata_i;
      unique case (1'b1)
         (size_i == SZ_BYTE): begin
            ext_o    = {{24{sgn_i & byte_w[7]}}, byte_w};
            merged_o = word_i;
            merged_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         (size_i == SZ_HALF): begin
            ext_o    = {{16{sgn_i & half_w[15]}}, half_w};
            merged_o = word_i;
            if (addr_i[1]) merged_o[31:16] = wdata_i[15:0];
            else           merged_o[15:0]  = wdata_i[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// CPU-side initiator for the word-only data memory (RMW for sb/sh).
// Define DMEM_ALIGN_CHECK_EN to flag misaligned half/word accesses.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
   parameter int          MEM_WORDS = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_signed,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_done,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] SPAN = 32'(WORD_BYTES * MEM_WORDS);

   state_e      state_q;
   logic        we_q, sgn_q, busy_q, done_q, err_q;
   logic [1:0]  size_q, lane_q;
   logic [31:0] wdata_q, rdata_q, maddr_q, mwdata_q;

   logic [31:0] off_d;
   logic        mis_d, err_d;
   logic [31:0] ext_w, merged_w;

   assign off_d = cpu_addr - BASE_ADDR;

`ifdef DMEM_ALIGN_CHECK_EN
   assign mis_d = ((cpu_size == SZ_HALF) && cpu_addr[0]) ||
                  (cpu_size[1] && (cpu_addr[1:0] != 2'b00));
`else
   assign mis_d = 1'b0;
`endif

   assign err_d = mis_d || (off_d >= SPAN);

   dmem_lsu_lane u_lane (
      .word_i   (mem_rdata),
      .wdata_i  (wdata_q),
      .addr_i   (lane_q),
      .size_i   (size_q),
      .sgn_i    (sgn_q),
      .ext_o    (ext_w),
      .merged_o (merged_w)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         sgn_q    <= 1'b0;
         size_q   <= 2'b00;
         lane_q   <= 2'b00;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (cpu_req) begin
               we_q     <= cpu_we;
               sgn_q    <= cpu_signed;
               size_q   <= cpu_size;
               lane_q   <= cpu_addr[1:0];
               wdata_q  <= cpu_wdata;
               maddr_q  <= {cpu_addr[31:2], 2'b00};
               mwdata_q <= cpu_wdata;
               busy_q   <= 1'b1;
               if (err_d) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else if (cpu_we && cpu_size[1]) begin
                  state_q <= WR;
               end else begin
                  state_q <= RD;
               end
            end
            RD: begin
               if (we_q) begin
                  mwdata_q <= merged_w;
                  state_q  <= WR;
               end else begin
                  rdata_q <= ext_w;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            WR: begin
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Decoded from state only so an async reset kills a write instantly.
   assign mem_write = (state_q == WR);
   assign cpu_busy  = busy_q;
   assign cpu_done  = done_q;
   assign cpu_err   = err_q;
   assign cpu_rdata = rdata_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a negedge-write word memory model.
// Expectations are hand-computed constants tracked per step.
module tb_dmem_lsu;

   localparam logic [31:0] BASE = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_signed;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_busy, cpu_done, cpu_err, mem_write;
   logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:2047];
   logic [31:0] moff;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_rd = '0;

   always #5 clk = ~clk;

   dmem_lsu dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_size   (cpu_size),
      .cpu_signed (cpu_signed),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_busy   (cpu_busy),
      .cpu_done   (cpu_done),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   assign moff      = mem_addr - BASE;
   assign mem_rdata = mem[moff[12:2]];

   always @(negedge clk) begin
      if (mem_write) begin
         mem[moff[12:2]] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (cpu_done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xact(input string tag, input logic we,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_rd);
      int lat;
      int w0;
      lat = 0;
      @(negedge clk);
      w0 = wr_cnt;
      cpu_req = 1'b1; cpu_we = we; cpu_size = sz;
      cpu_signed = sg; cpu_addr = a; cpu_wdata = wd;
      @(posedge clk);
      #1;
      // scramble fields after accept; only the latched copy may matter
      cpu_we = ~we; cpu_wdata = ~wd; cpu_addr = a ^ 32'h3;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(negedge clk);
         if (cpu_done) lat = i;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".err"}, {31'd0, cpu_err}, {31'd0, exp_err});
      if (!we && !exp_err) last_rd = exp_rd;
      chk({tag, ".rdata"}, cpu_rdata, last_rd);
      cpu_req = 1'b0;
      @(negedge clk);
      chk({tag, ".idle"}, {30'd0, cpu_busy, cpu_done}, 32'd0);
      chk({tag, ".writes"}, 32'(wr_cnt - w0),
          (we && !exp_err) ? 32'd1 : 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00;
      cpu_signed = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      #2;
      chk("rst.async", {30'd0, cpu_busy, mem_write}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle.flags", {29'd0, cpu_busy, cpu_done, cpu_err}, 32'd0);
      chk("idle.rdata", cpu_rdata, 32'd0);
      chk("idle.maddr", mem_addr, 32'd0);
      chk("idle.mwdata", mem_wdata, 32'd0);
      chk("idle.writes", 32'(wr_cnt), 32'd0);

      xact("sw", 1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF,
           2, 1'b0, 32'h0);
      chk("sw.mem", mem[2], 32'hDEAD_BEEF);
      xact("lw", 1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0,
           2, 1'b0, 32'hDEAD_BEEF);

      mem[4] = 32'h1122_3344;
      xact("sb", 1'b1, 2'b00, 1'b0, 32'h1001_0011, 32'h1234_56AA,
           3, 1'b0, 32'h0);
      chk("sb.mem", mem[4], 32'h1122_AA44);
      xact("lb", 1'b0, 2'b00, 1'b1, 32'h1001_0011, 32'h0,
           2, 1'b0, 32'hFFFF_FFAA);
      xact("lbu", 1'b0, 2'b00, 1'b0, 32'h1001_0011, 32'h0,
           2, 1'b0, 32'h0000_00AA);
      xact("lb0", 1'b0, 2'b00, 1'b1, 32'h1001_0010, 32'h0,
           2, 1'b0, 32'h0000_0044);

      xact("sh", 1'b1, 2'b01, 1'b0, 32'h1001_0012, 32'hFFFF_8001,
           3, 1'b0, 32'h0);
      chk("sh.mem", mem[4], 32'h8001_AA44);
      xact("lh", 1'b0, 2'b01, 1'b1, 32'h1001_0012, 32'h0,
           2, 1'b0, 32'hFFFF_8001);
      xact("lhu", 1'b0, 2'b01, 1'b0, 32'h1001_0012, 32'h0,
           2, 1'b0, 32'h0000_8001);
      xact("lhu0", 1'b0, 2'b01, 1'b0, 32'h1001_0010, 32'h0,
           2, 1'b0, 32'h0000_AA44);

      xact("oor", 1'b0, 2'b10, 1'b0, 32'h1001_2000, 32'h0,
           1, 1'b1, 32'h0);
      xact("oor.sw", 1'b1, 2'b10, 1'b0, 32'h1001_2000, 32'h5555_5555,
           1, 1'b1, 32'h0);
      xact("below", 1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0,
           1, 1'b1, 32'h0);
      mem[2047] = 32'hCAFE_F00D;
      xact("top", 1'b0, 2'b10, 1'b0, 32'h1001_1FFC, 32'h0,
           2, 1'b0, 32'hCAFE_F00D);
`ifdef DMEM_ALIGN_CHECK_EN
      xact("mis.lh", 1'b0, 2'b01, 1'b1, 32'h1001_0001, 32'h0,
           1, 1'b1, 32'h0);
      xact("mis.lw", 1'b0, 2'b10, 1'b0, 32'h1001_000A, 32'h0,
           1, 1'b1, 32'h0);
`else
      xact("na.lh", 1'b0, 2'b01, 1'b1, 32'h1001_0013, 32'h0,
           2, 1'b0, 32'hFFFF_8001);
      xact("na.lw", 1'b0, 2'b10, 1'b0, 32'h1001_000A, 32'h0,
           2, 1'b0, 32'hDEAD_BEEF);
`endif

      // reset while the RMW store sits in WR
      mem[8] = 32'h5566_7788;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00;
      cpu_signed = 1'b0; cpu_addr = 32'h1001_0020; cpu_wdata = 32'h99;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rstwr.pre", {31'd0, mem_write}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstwr.drop", {30'd0, mem_write, cpu_busy}, 32'd0);
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      begin
         int d0;
         d0 = done_cnt;
         repeat (4) @(negedge clk);
         chk("rstwr.nodone", 32'(done_cnt - d0), 32'd0);
      end
      chk("rstwr.mem", mem[8], 32'h5566_7788);
      chk("rstwr.rdata", cpu_rdata, 32'd0);
      last_rd = '0;

      xact("after", 1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0,
           2, 1'b0, 32'hDEAD_BEEF);
      chk("after.mem", mem[2], 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
